// File: rtl/tff_counter_pkg.sv
// rtl/tff_counter_pkg.sv - shared constants and helpers for the toggle-cell counter
//
// Purpose : direction encodings and a constant ceil-log2 helper used to
//           check the modulus against the counter width at elaboration.
// Ports   : none (package)

package tff_counter_pkg;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // Number of bits needed to hold values 0..value-1 (0 for value <= 1).
    function automatic int clog2(input longint unsigned value);
        longint unsigned v;
        int              r;
        v = (value > 0) ? value - 1 : 0;
        r = 0;
        for (int i = 0; i < 64; i++) begin
            if (v != 0) begin
                r++;
                v = v >> 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/tff_counter_t_ff_cell.sv
// rtl/tff_counter_t_ff_cell.sv - single-bit toggle flip-flop cell
//
// Purpose : one state bit of the counter; flips on a rising clock edge when
//           t is high, otherwise holds.
// Ports   : clk   in  rising-edge clock
//           n_rst in  asynchronous active-low reset, clears q to 0
//           t     in  toggle request for the next edge
//           q     out current bit value (registered)

module t_ff_cell (
    input  logic clk,
    input  logic n_rst,
    input  logic t,
    output logic q
);

    logic q_q;
    logic q_d;

    assign q_d = q_q ^ t;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/tff_counter.sv
// rtl/tff_counter.sv - modulo-N up/down counter built from toggle flip-flop cells
//
// Purpose : counts 0..MOD_VAL-1 up or down with synchronous clear and a
//           clamped synchronous load; flags the terminal count combinationally
//           and pulses wrap for one cycle after each wrap-around.
// Ports   : clk      in  rising-edge clock
//           n_rst    in  asynchronous active-low reset (q=0, wrap=0)
//           en       in  count enable
//           clr      in  synchronous clear (highest priority)
//           load     in  synchronous load of load_val (clamped to MOD_VAL-1)
//           load_val in  load value, WIDTH bits
//           up_dn    in  direction, 1 = up, 0 = down
//           q        out current count (registered)
//           tc       out terminal count, high when the coming edge wraps
//           wrap     out one-cycle pulse aligned with the wrapped count

module tff_counter
    import tff_counter_pkg::*;
#(
    parameter int              WIDTH   = 8,
    parameter longint unsigned MOD_VAL = 256
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             up_dn,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    // MOD_VAL-1 is formed at 64 bits and then narrowed, so MOD_VAL == 2**WIDTH
    // yields an all-ones terminal value instead of overflowing.
    localparam logic [63:0]      MOD_M1_64 = 64'(MOD_VAL) - 64'd1;
    localparam logic [WIDTH-1:0] MAX_VAL   = MOD_M1_64[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

    if ((WIDTH < 1) || (WIDTH > 32) || (MOD_VAL < 2) || (clog2(MOD_VAL) > WIDTH)) begin : g_bad_param
        $error("tff_counter: illegal WIDTH/MOD_VAL combination");
    end

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] t_vec;
    logic             wrap_q;
    logic             wrap_d;
    logic             at_max;
    logic             at_zero;
    logic             wrap_cond;

    assign at_max  = (q_q == MAX_VAL);
    assign at_zero = (q_q == '0);

    // Same condition drives tc and the wrap branch of the next-state logic,
    // so the flag always matches the edge that actually wraps.
    assign wrap_cond = en & ~clr & ~load &
                       (((up_dn == DIR_UP) & at_max) | ((up_dn == DIR_DN) & at_zero));

    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        if (clr) begin
            q_d = '0;
        end else if (load) begin
            q_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
        end else if (en) begin
            if (wrap_cond) begin
                q_d    = (up_dn == DIR_UP) ? '0 : MAX_VAL;
                wrap_d = 1'b1;
            end else if (up_dn == DIR_UP) begin
                q_d = q_q + ONE;
            end else begin
                q_d = q_q - ONE;
            end
        end
    end

    // Every update, including clear and load, reaches the state only as a
    // per-bit toggle request; cells never see a direct data write.
    assign t_vec = q_q ^ q_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        t_ff_cell u_cell (
            .clk   (clk),
            .n_rst (n_rst),
            .t     (t_vec[i]),
            .q     (q_q[i])
        );
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign q    = q_q;
    assign tc   = wrap_cond;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_tff_counter.sv
// tb/tb_tff_counter.sv - self-checking bench for tff_counter

module tb_tff_counter;

    logic       clk;
    logic       n_rst;
    logic       en;
    logic       clr;
    logic       load;
    logic       up_dn;
    logic [3:0] lv;

    logic [3:0] q_a;
    logic [2:0] q_b;
    logic [0:0] q_c;
    logic       tc_a, tc_b, tc_c;
    logic       wrap_a, wrap_b, wrap_c;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state per instance: A = W4/M10, B = W3/M8, C = W1/M2
    int mod_m [3] = '{10, 8, 2};
    int wid_m [3] = '{4, 3, 1};
    int mq    [3] = '{0, 0, 0};
    int mw    [3] = '{0, 0, 0};

    tff_counter #(.WIDTH(4), .MOD_VAL(10)) u_a (
        .clk(clk), .n_rst(n_rst), .en(en), .clr(clr), .load(load),
        .load_val(lv[3:0]), .up_dn(up_dn), .q(q_a), .tc(tc_a), .wrap(wrap_a)
    );

    tff_counter #(.WIDTH(3), .MOD_VAL(8)) u_b (
        .clk(clk), .n_rst(n_rst), .en(en), .clr(clr), .load(load),
        .load_val(lv[2:0]), .up_dn(up_dn), .q(q_b), .tc(tc_b), .wrap(wrap_b)
    );

    tff_counter #(.WIDTH(1), .MOD_VAL(2)) u_c (
        .clk(clk), .n_rst(n_rst), .en(en), .clr(clr), .load(load),
        .load_val(lv[0:0]), .up_dn(up_dn), .q(q_c), .tc(tc_c), .wrap(wrap_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Counter behaviour in plain integer arithmetic
    always @(posedge clk or negedge n_rst) begin
        for (int i = 0; i < 3; i++) begin
            int lvt;
            lvt = int'(lv) % (1 << wid_m[i]);
            if (!n_rst) begin
                mq[i] = 0;
                mw[i] = 0;
            end else if (clr) begin
                mq[i] = 0;
                mw[i] = 0;
            end else if (load) begin
                mq[i] = (lvt > mod_m[i] - 1) ? mod_m[i] - 1 : lvt;
                mw[i] = 0;
            end else if (en) begin
                if (up_dn) begin
                    mw[i] = (mq[i] == mod_m[i] - 1) ? 1 : 0;
                    mq[i] = (mq[i] + 1) % mod_m[i];
                end else begin
                    mw[i] = (mq[i] == 0) ? 1 : 0;
                    mq[i] = (mq[i] + mod_m[i] - 1) % mod_m[i];
                end
            end else begin
                mw[i] = 0;
            end
        end
    end

    function automatic int model_tc(input int i);
        if (!en || clr || load) return 0;
        if (up_dn) return (mq[i] == mod_m[i] - 1) ? 1 : 0;
        return (mq[i] == 0) ? 1 : 0;
    endfunction

    always @(negedge clk) begin
        check("cmp_q_a",    int'(q_a),    mq[0]);
        check("cmp_wrap_a", int'(wrap_a), mw[0]);
        check("cmp_tc_a",   int'(tc_a),   model_tc(0));
        check("cmp_q_b",    int'(q_b),    mq[1]);
        check("cmp_wrap_b", int'(wrap_b), mw[1]);
        check("cmp_tc_b",   int'(tc_b),   model_tc(1));
        check("cmp_q_c",    int'(q_c),    mq[2]);
        check("cmp_wrap_c", int'(wrap_c), mw[2]);
        check("cmp_tc_c",   int'(tc_c),   model_tc(2));
    end

    task automatic drive(input logic e, input logic c, input logic l,
                         input logic u, input logic [3:0] v);
        en    = e;
        clr   = c;
        load  = l;
        up_dn = u;
        lv    = v;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    initial begin
        n_rst = 1'b1;
        en = 0; clr = 0; load = 0; up_dn = 1; lv = 0;
        #1 n_rst = 1'b0;
        #1;
        check("rst_q",    int'(q_a),    0);
        check("rst_wrap", int'(wrap_a), 0);
        tick;
        n_rst = 1'b1;

        // Up count through the terminal value
        drive(1, 0, 0, 1, 0);
        check("up_tc_at_0", int'(tc_a), 0);
        repeat (9) tick;
        check("up_q9",  int'(q_a),  9);
        check("up_tc9", int'(tc_a), 1);
        tick;
        check("up_wrap_q",  int'(q_a),    0);
        check("up_wrap",    int'(wrap_a), 1);
        tick;
        check("up_after_q",    int'(q_a),    1);
        check("up_after_wrap", int'(wrap_a), 0);

        // Down count from zero
        drive(0, 1, 0, 1, 0);
        tick;
        check("clr_q", int'(q_a), 0);
        drive(1, 0, 0, 0, 0);
        check("dn_tc0", int'(tc_a), 1);
        tick;
        check("dn_wrap_q", int'(q_a),    9);
        check("dn_wrap",   int'(wrap_a), 1);
        tick;
        check("dn_q8",      int'(q_a),    8);
        check("dn_wrap_lo", int'(wrap_a), 0);

        // Loads: priority over en, clamp, clr beats load
        drive(1, 0, 1, 1, 5);
        check("ld_tc", int'(tc_a), 0);
        tick;
        check("ld_q5",   int'(q_a),    5);
        check("ld_wrap", int'(wrap_a), 0);
        drive(0, 0, 1, 1, 12);
        tick;
        check("ld_clamp", int'(q_a), 9);
        check("ld_b_trunc", int'(q_b), 4);
        drive(0, 1, 1, 1, 7);
        tick;
        check("clr_beats_ld", int'(q_a), 0);

        // Async reset mid-cycle at q=7 while B and C show a wrap
        drive(0, 0, 1, 1, 8);
        tick;
        drive(1, 0, 0, 0, 0);
        tick;
        check("pre_rst_q",      int'(q_a),    7);
        check("pre_rst_wrap_b", int'(wrap_b), 1);
        check("pre_rst_wrap_c", int'(wrap_c), 1);
        drive(0, 0, 0, 1, 0);
        n_rst = 1'b0;
        #1;
        check("arst_q",      int'(q_a),    0);
        check("arst_wrap_a", int'(wrap_a), 0);
        check("arst_wrap_b", int'(wrap_b), 0);
        check("arst_wrap_c", int'(wrap_c), 0);
        tick;
        n_rst = 1'b1;
        drive(1, 0, 0, 1, 0);
        tick;
        check("resume_q1", int'(q_a), 1);
        tick;
        tick;
        check("resume_q3", int'(q_a), 3);

        // Hold
        drive(0, 0, 0, 1, 0);
        for (int k = 0; k < 5; k++) begin
            tick;
            check("hold_q",    int'(q_a),    3);
            check("hold_wrap", int'(wrap_a), 0);
            check("hold_tc",   int'(tc_a),   0);
        end

        // Direction flipping every cycle
        drive(0, 0, 1, 1, 4);
        tick;
        check("flip_start", int'(q_a), 4);
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, 0, (k % 2 == 0) ? 1'b1 : 1'b0, 0);
            tick;
            check("flip_q", int'(q_a), (k % 2 == 0) ? 5 : 4);
        end

        // Full-range modulus (B) and MOD_VAL=2 (C) wraps, incl. back-to-back
        drive(0, 0, 1, 1, 7);
        tick;
        check("b_load7", int'(q_b), 7);
        drive(1, 0, 0, 1, 0);
        check("b_tc7", int'(tc_b), 1);
        tick;
        check("b_wrap_q",  int'(q_b),    0);
        check("b_wrap",    int'(wrap_b), 1);
        check("c_wrap_up", int'(wrap_c), 1);
        drive(1, 0, 0, 0, 0);
        tick;
        check("b_b2b_q",    int'(q_b),    7);
        check("b_b2b_wrap", int'(wrap_b), 1);
        check("c_b2b_q",    int'(q_c),    1);
        check("c_b2b_wrap", int'(wrap_c), 1);
        drive(1, 0, 0, 1, 0);
        tick;
        check("c_q0",    int'(q_c),    0);
        check("c_wrap1", int'(wrap_c), 1);
        tick;
        check("c_q1",    int'(q_c),    1);
        check("c_wrap0", int'(wrap_c), 0);
        tick;
        check("c_q0b",    int'(q_c),    0);
        check("c_wrap1b", int'(wrap_c), 1);

        drive(0, 0, 0, 1, 0);
        tick;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
